// File: rtl/led_switch_io.sv
// rtl/led_switch_io.sv - LED mode/PWM driver and debounced switch inputs for the HPS PIO exports
module led_switch_io #(
    parameter int LED_COUNT       = 8,
    parameter int SWITCH_COUNT    = 4,
    parameter int PWM_BITS        = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BLINK_DIV       = 25000000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cfg_valid,
    input  logic [2*LED_COUNT-1:0]        led_mode,
    input  logic [PWM_BITS*LED_COUNT-1:0] led_duty,
    output logic                          cfg_pending,
    output logic [LED_COUNT-1:0]          led,
    input  logic [SWITCH_COUNT-1:0]       switch,
    output logic [SWITCH_COUNT-1:0]       switch_state,
    output logic [SWITCH_COUNT-1:0]       switch_changed
);
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [PWM_BITS-1:0]           pwm_cnt;
    logic [BLINK_W-1:0]            blink_cnt;
    logic                          blink_phase;
    logic [2*LED_COUNT-1:0]        shadow_mode;
    logic [PWM_BITS*LED_COUNT-1:0] shadow_duty;
    logic [2*LED_COUNT-1:0]        active_mode;
    logic [PWM_BITS*LED_COUNT-1:0] active_duty;
    logic [LED_COUNT-1:0]          led_next;
    logic                          apply;

    logic [SWITCH_COUNT-1:0]       sync_meta;
    logic [SWITCH_COUNT-1:0]       sync;
    logic [DEB_W-1:0]              deb_cnt [SWITCH_COUNT];

    // Last cycle of the PWM period: config swaps here so the next period starts clean.
    assign apply = &pwm_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_mode <= '0;
            shadow_duty <= '0;
            active_mode <= '0;
            active_duty <= '0;
            cfg_pending <= 1'b0;
        end else if (cfg_valid && apply) begin
            active_mode <= led_mode;
            active_duty <= led_duty;
            cfg_pending <= 1'b0;
        end else begin
            if (apply && cfg_pending) begin
                active_mode <= shadow_mode;
                active_duty <= shadow_duty;
                cfg_pending <= 1'b0;
            end
            if (cfg_valid) begin
                shadow_mode <= led_mode;
                shadow_duty <= led_duty;
                cfg_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        led_next = '0;
        for (int i = 0; i < LED_COUNT; i++) begin
            case (active_mode[2*i +: 2])
                2'b00:   led_next[i] = 1'b0;
                2'b01:   led_next[i] = 1'b1;
                2'b10:   led_next[i] = blink_phase;
                default: led_next[i] = (pwm_cnt < active_duty[PWM_BITS*i +: PWM_BITS]);
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            led <= '0;
        end else begin
            led <= led_next;
        end
    end

    // Each switch bit: two-flop synchroniser, then accept a level only after it holds long enough.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta      <= '0;
            sync           <= '0;
            switch_state   <= '0;
            switch_changed <= '0;
            for (int i = 0; i < SWITCH_COUNT; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync_meta      <= switch;
            sync           <= sync_meta;
            switch_changed <= '0;
            for (int i = 0; i < SWITCH_COUNT; i++) begin
                if (sync[i] == switch_state[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    switch_state[i]   <= sync[i];
                    switch_changed[i] <= 1'b1;
                    deb_cnt[i]        <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_led_switch_io.sv
// tb/tb_led_switch_io.sv - directed self-checking bench for led_switch_io
module tb_led_switch_io;
    localparam int LED_COUNT       = 2;
    localparam int SWITCH_COUNT    = 2;
    localparam int PWM_BITS        = 4;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int BLINK_DIV       = 8;

    logic                          clock = 1'b0;
    logic                          reset;
    logic                          cfg_valid;
    logic [2*LED_COUNT-1:0]        led_mode;
    logic [PWM_BITS*LED_COUNT-1:0] led_duty;
    logic                          cfg_pending;
    logic [LED_COUNT-1:0]          led;
    logic [SWITCH_COUNT-1:0]       switch;
    logic [SWITCH_COUNT-1:0]       switch_state;
    logic [SWITCH_COUNT-1:0]       switch_changed;

    int checks = 0;
    int errors = 0;
    int n = 0;
    int pulses0 = 0;
    int pulses1 = 0;

    always #5 clock = ~clock;

    led_switch_io #(
        .LED_COUNT(LED_COUNT),
        .SWITCH_COUNT(SWITCH_COUNT),
        .PWM_BITS(PWM_BITS),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cfg_valid(cfg_valid),
        .led_mode(led_mode),
        .led_duty(led_duty),
        .cfg_pending(cfg_pending),
        .led(led),
        .switch(switch),
        .switch_state(switch_state),
        .switch_changed(switch_changed)
    );

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, actual, expected, n);
        end
    endtask

    // n = posedges since reset release; visible pwm_cnt is n mod 16.
    task automatic tick;
        @(posedge clock);
        #1;
        n++;
        pulses0 += int'(switch_changed[0]);
        pulses1 += int'(switch_changed[1]);
    endtask

    task automatic wait_pwm(input int v);
        while ((n % 16) != v) tick();
    endtask

    task automatic do_reset;
        reset = 1'b1;
        cfg_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        n = 0;
    endtask

    task automatic send_cfg(input logic [3:0] m, input logic [7:0] d);
        cfg_valid = 1'b1;
        led_mode = m;
        led_duty = d;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Called at visible pwm 0 right after an apply; walks one full period.
    task automatic check_period(input int duty, input logic ch1);
        logic [1:0] e;
        for (int p = 1; p <= 16; p++) begin
            tick();
            e = {ch1, ((p - 1) < duty)};
            check_value("pwm_led", led, e);
            check_value("pend_idle", cfg_pending, 0);
        end
    endtask

    initial begin
        logic [1:0] e;
        reset = 1'b1;
        cfg_valid = 1'b0;
        led_mode = '0;
        led_duty = '0;
        switch = '0;
        do_reset();
        check_value("rst_led", led, 0);
        check_value("rst_pending", cfg_pending, 0);
        check_value("rst_state", switch_state, 0);
        check_value("rst_changed", switch_changed, 0);

        // idle: nothing moves for 100 cycles
        pulses0 = 0;
        pulses1 = 0;
        for (int i = 0; i < 100; i++) tick();
        check_value("idle_led", led, 0);
        check_value("idle_state", switch_state, 0);
        check_value("idle_pulses", pulses0 + pulses1, 0);

        // ch0 PWM duty 5, ch1 on, requested at pwm 3
        wait_pwm(3);
        send_cfg(4'b0111, 8'h05);
        check_value("pend_rise", cfg_pending, 1);
        wait_pwm(15);
        check_value("pend_hold", cfg_pending, 1);
        tick();
        check_value("pend_fall", cfg_pending, 0);
        check_period(5, 1'b1);

        // two writes while pending: only the last one lands
        wait_pwm(2);
        send_cfg(4'b0011, 8'h05);
        check_value("pend_w1", cfg_pending, 1);
        wait_pwm(8);
        send_cfg(4'b0111, 8'h09);
        check_value("pend_w2", cfg_pending, 1);
        while ((n % 16) != 15) begin
            tick();
            check_value("old_cfg_ch1", led[1], 1);
        end
        tick();
        check_value("pend_fall2", cfg_pending, 0);
        check_period(9, 1'b1);

        // write on the apply cycle takes effect at once
        wait_pwm(15);
        send_cfg(4'b0011, 8'h0C);
        check_value("direct_pend", cfg_pending, 0);
        check_period(12, 1'b0);

        // blink: 8 high / 8 low, phase counted from reset release
        wait_pwm(15);
        send_cfg(4'b0010, 8'h00);
        for (int i = 0; i < 32; i++) begin
            tick();
            e = {1'b0, 1'(((n - 1) >> 3) & 1)};
            check_value("blink_led", led, e);
        end
        wait_pwm(10);
        check_value("blink_high", led, 2'b01);
        send_cfg(4'b0110, 8'h00);
        check_value("pend_pre_rst", cfg_pending, 1);
        reset = 1'b1;
        tick();
        check_value("rst_mid_led", led, 0);
        check_value("rst_mid_pend", cfg_pending, 0);
        tick();
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            check_value("post_rst_led", led, 0);
        end
        check_value("post_rst_pend", cfg_pending, 0);

        // switch[0] bounce then hold high
        pulses0 = 0;
        pulses1 = 0;
        switch[0] = 1'b1;
        tick();
        tick();
        switch[0] = 1'b0;
        tick();
        tick();
        switch[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 5) check_value("sw0_not_yet", switch_state[0], 0);
            if (i == 6) begin
                check_value("sw0_state", switch_state[0], 1);
                check_value("sw0_pulse", switch_changed[0], 1);
            end
            if (i == 7) check_value("sw0_pulse_end", switch_changed[0], 0);
        end
        check_value("sw0_pulse_count", pulses0, 1);

        // switch[0] falls while switch[1] glitches for 3 cycles
        pulses0 = 0;
        pulses1 = 0;
        switch[0] = 1'b0;
        switch[1] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 3) switch[1] = 1'b0;
            if (i == 6) begin
                check_value("sw0_fall_state", switch_state[0], 0);
                check_value("sw0_fall_pulse", switch_changed[0], 1);
            end
        end
        check_value("sw0_fall_count", pulses0, 1);
        check_value("sw1_glitch_count", pulses1, 0);
        check_value("sw_final_state", switch_state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
